dma_burst_sequencer: RTL and testbench

//  Upstream feeder for the memory latency injector. Accepts one transfer descriptor (addr, length, is_dram)
//  and splits it into boundary-aligned bursts of at most MAX_BURST_BYTES, issued on a ready/valid request channel.

---
 rtl/dma_seq_pkg.sv | 27 ++
 rtl/dma_chunk_calc.sv | 33 +++
 rtl/dma_burst_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_dma_burst_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_seq_pkg.sv
// Shared types for the DMA burst sequencer: FSM state encoding and
// done_status bit positions.
package dma_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  localparam int DONE_ABORT    = 0;
  localparam int DONE_MISMATCH = 1;
  localparam int DONE_SPURIOUS = 2;
  localparam int DONE_W        = 3;

  function automatic logic [DONE_W-1:0] pack_status(input logic aborted,
                                                    input logic mismatch,
                                                    input logic spurious);
    logic [DONE_W-1:0] st;
    st                = {DONE_W{1'b0}};
    st[DONE_ABORT]    = aborted;
    st[DONE_MISMATCH] = mismatch;
    st[DONE_SPURIOUS] = spurious;
    return st;
  endfunction

endpackage

// File: rtl/dma_chunk_calc.sv
// Combinational burst sizing: the largest burst that neither exceeds the
// remaining bytes nor crosses a MAX_BURST_BYTES-aligned boundary.
module dma_chunk_calc #(
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 32,
  parameter int SIZE_WIDTH      = 16,
  parameter int MAX_BURST_BYTES = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  remaining,
  output logic [SIZE_WIDTH-1:0] chunk
);

  localparam logic [LEN_WIDTH-1:0] BURST_LEN  = LEN_WIDTH'(MAX_BURST_BYTES);
  localparam logic [LEN_WIDTH-1:0] BURST_MASK = LEN_WIDTH'(MAX_BURST_BYTES - 32'sd1);

  logic [LEN_WIDTH-1:0] offset_s;
  logic [LEN_WIDTH-1:0] room_s;
  logic [LEN_WIDTH-1:0] chunk_len_s;

  // Bytes left before the next alignment boundary, clipped to what remains.
  always_comb begin
    offset_s = LEN_WIDTH'(addr) & BURST_MASK;
    room_s   = BURST_LEN - offset_s;
    if (remaining < room_s) begin
      chunk_len_s = remaining;
    end else begin
      chunk_len_s = room_s;
    end
    chunk = SIZE_WIDTH'(chunk_len_s);
  end

endmodule

// File: rtl/dma_burst_sequencer.sv
// Splits one DMA descriptor into boundary-aligned bursts on a ready/valid
// channel, tracks in-order responses against a credit limit, reports status.
module dma_burst_sequencer
  import dma_seq_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int SIZE_WIDTH      = 16,
  parameter int LEN_WIDTH       = 32,
  parameter int MAX_BURST_BYTES = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               desc_valid,
  output logic                               desc_ready,
  input  logic [ADDR_WIDTH-1:0]              desc_addr,
  input  logic [LEN_WIDTH-1:0]               desc_len,
  input  logic                               desc_is_dram,
  input  logic                               abort,
  output logic                               req_valid,
  input  logic                               req_ready,
  output logic [ADDR_WIDTH-1:0]              req_addr,
  output logic                               req_is_dram,
  output logic [SIZE_WIDTH-1:0]              req_size_bytes,
  input  logic                               resp_valid,
  input  logic [SIZE_WIDTH-1:0]              resp_size_bytes,
  output logic                               done,
  output logic [2:0]                         done_status,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic [31:0]                        bursts_issued,
  output logic [31:0]                        bp_stall_cycles,
  output logic [31:0]                        credit_stall_cycles
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OUT_W-1:0]     OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]     OUT_ZERO = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0]     OUT_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};

  seq_state_e state_r, state_nxt_s;

  logic [ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
  logic [LEN_WIDTH-1:0]  rem_r, rem_nxt_s, rem_after_s;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  bytes_r, bytes_nxt_s;
  logic [OUT_W-1:0]      out_r, out_nxt_s;
  logic                  is_dram_r;
  logic                  abort_r, abort_nxt_s;
  logic                  spur_r, spur_nxt_s;
  logic                  req_valid_r, req_valid_nxt_s;
  logic [SIZE_WIDTH-1:0] req_size_r, chunk_nxt_s;
  logic                  desc_ready_r;
  logic                  done_r, done_s;
  logic [2:0]            status_r, status_s;
  logic [31:0]           bursts_r, bp_r, credit_r;

  logic desc_hs_s, req_hs_s, resp_ok_s, resp_spur_s;

  dma_chunk_calc #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .LEN_WIDTH       (LEN_WIDTH),
    .SIZE_WIDTH      (SIZE_WIDTH),
    .MAX_BURST_BYTES (MAX_BURST_BYTES)
  ) u_chunk (
    .addr      (addr_nxt_s),
    .remaining (rem_nxt_s),
    .chunk     (chunk_nxt_s)
  );

  // Transfer FSM; done is raised in the cycle that returns to IDLE.
  always_comb begin
    desc_hs_s   = desc_valid & desc_ready_r;
    req_hs_s    = req_valid_r & req_ready;
    rem_after_s = rem_r - LEN_WIDTH'(req_size_r);
    state_nxt_s = state_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (desc_hs_s) begin
          state_nxt_s = (desc_len != LEN_ZERO) ? ISSUE : DRAIN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (req_hs_s && (rem_after_s == LEN_ZERO)) begin
          state_nxt_s = DRAIN;
        end else if (abort_r && !req_valid_r) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DRAIN: begin
        if ((out_r == OUT_ZERO) && !resp_valid) begin
          state_nxt_s = IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Address walk, credits, byte accounting and next request decision.
  always_comb begin
    resp_ok_s   = resp_valid & (out_r != OUT_ZERO);
    resp_spur_s = resp_valid & (out_r == OUT_ZERO);

    if (desc_hs_s) begin
      addr_nxt_s = desc_addr;
      rem_nxt_s  = desc_len;
    end else if (req_hs_s) begin
      addr_nxt_s = addr_r + ADDR_WIDTH'(req_size_r);
      rem_nxt_s  = rem_after_s;
    end else begin
      addr_nxt_s = addr_r;
      rem_nxt_s  = rem_r;
    end

    case ({req_hs_s, resp_ok_s})
      2'b10:   out_nxt_s = out_r + OUT_ONE;
      2'b01:   out_nxt_s = out_r - OUT_ONE;
      default: out_nxt_s = out_r;
    endcase

    if (desc_hs_s) begin
      bytes_nxt_s = LEN_ZERO;
    end else if (resp_ok_s) begin
      bytes_nxt_s = bytes_r + LEN_WIDTH'(resp_size_bytes);
    end else begin
      bytes_nxt_s = bytes_r;
    end

    if (state_nxt_s == IDLE) begin
      abort_nxt_s = 1'b0;
    end else if ((state_r != IDLE) && abort) begin
      abort_nxt_s = 1'b1;
    end else begin
      abort_nxt_s = abort_r;
    end

    if (done_s) begin
      spur_nxt_s = 1'b0;
    end else begin
      spur_nxt_s = spur_r | resp_spur_s;
    end

    // A presented request is held regardless of abort until it is taken.
    if (req_valid_r && !req_ready) begin
      req_valid_nxt_s = 1'b1;
    end else if ((state_nxt_s == ISSUE) && (rem_nxt_s != LEN_ZERO) &&
                 !abort_nxt_s && (out_nxt_s < OUT_MAX)) begin
      req_valid_nxt_s = 1'b1;
    end else begin
      req_valid_nxt_s = 1'b0;
    end

    status_s = pack_status(abort_r, !abort_r && (bytes_r != len_r), spur_r);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      rem_r        <= LEN_ZERO;
      len_r        <= LEN_ZERO;
      bytes_r      <= LEN_ZERO;
      out_r        <= OUT_ZERO;
      is_dram_r    <= 1'b0;
      abort_r      <= 1'b0;
      spur_r       <= 1'b0;
      req_valid_r  <= 1'b0;
      req_size_r   <= {SIZE_WIDTH{1'b0}};
      desc_ready_r <= 1'b1;
      done_r       <= 1'b0;
      status_r     <= 3'b000;
      bursts_r     <= 32'd0;
      bp_r         <= 32'd0;
      credit_r     <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      addr_r       <= addr_nxt_s;
      rem_r        <= rem_nxt_s;
      bytes_r      <= bytes_nxt_s;
      out_r        <= out_nxt_s;
      abort_r      <= abort_nxt_s;
      spur_r       <= spur_nxt_s;
      req_valid_r  <= req_valid_nxt_s;
      req_size_r   <= chunk_nxt_s;
      desc_ready_r <= (state_nxt_s == IDLE) && !done_s;
      done_r       <= done_s;
      status_r     <= done_s ? status_s : 3'b000;
      if (desc_hs_s) begin
        len_r     <= desc_len;
        is_dram_r <= desc_is_dram;
      end
      bursts_r <= bursts_r + {31'd0, req_hs_s};
      bp_r     <= bp_r + {31'd0, req_valid_r & ~req_ready};
      credit_r <= credit_r + {31'd0, (state_r == ISSUE) && (rem_r != LEN_ZERO) &&
                                     (out_r >= OUT_MAX)};
    end
  end

  assign desc_ready          = desc_ready_r;
  assign req_valid           = req_valid_r;
  assign req_addr            = addr_r;
  assign req_is_dram         = is_dram_r;
  assign req_size_bytes      = req_size_r;
  assign done                = done_r;
  assign done_status         = status_r;
  assign outstanding         = out_r;
  assign bursts_issued       = bursts_r;
  assign bp_stall_cycles     = bp_r;
  assign credit_stall_cycles = credit_r;

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Self-checking bench for dma_burst_sequencer: directed and randomized
// descriptors checked against an arithmetic burst-split reference model.
module tb_dma_burst_sequencer;

  localparam int AW = 32;
  localparam int SW = 16;
  localparam int LW = 32;
  localparam int MB = 64;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          desc_valid, desc_ready, desc_is_dram, abort;
  logic [AW-1:0] desc_addr;
  logic [LW-1:0] desc_len;
  logic          req_valid, req_is_dram;
  logic          req_ready = 1'b0;
  logic [AW-1:0] req_addr;
  logic [SW-1:0] req_size_bytes;
  logic          resp_valid = 1'b0;
  logic [SW-1:0] resp_size_bytes = '0;
  logic          done;
  logic [2:0]    done_status;
  logic [2:0]    outstanding;
  logic [31:0]   bursts_issued, bp_stall_cycles, credit_stall_cycles;

  dma_burst_sequencer dut (
    .clk(clk), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_len(desc_len), .desc_is_dram(desc_is_dram), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_is_dram(req_is_dram), .req_size_bytes(req_size_bytes),
    .resp_valid(resp_valid), .resp_size_bytes(resp_size_bytes),
    .done(done), .done_status(done_status), .outstanding(outstanding),
    .bursts_issued(bursts_issued), .bp_stall_cycles(bp_stall_cycles),
    .credit_stall_cycles(credit_stall_cycles)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [AW-1:0] exp_addr_q[$];
  int            exp_size_q[$];
  logic          exp_dram;
  int            pend_due_q[$];
  int            pend_size_q[$];
  int            lat = 3;
  bit            rand_lat = 1'b0;
  bit            rand_ready = 1'b0;
  logic          ready_ctl = 1'b1;
  int            spur_req = 0, spur_done = 0;
  int            corrupt_req = 0, corrupt_done = 0;
  int            resp_sent = 0, valid_cycles = 0, max_out = 0;
  int            exp_bursts = 0;
  logic          held = 1'b0;
  logic [AW-1:0] held_addr;
  logic [SW-1:0] held_size;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference burst split: plain arithmetic over the aligned-boundary rule.
  task automatic plan(input logic [AW-1:0] a, input logic [LW-1:0] len, input logic dram);
    logic [AW-1:0] cur;
    longint        rem, room, c;
    cur = a;
    rem = len;
    exp_dram = dram;
    while (rem > 0) begin
      room = MB - (cur % MB);
      c    = (rem < room) ? rem : room;
      exp_addr_q.push_back(cur);
      exp_size_q.push_back(int'(c));
      cur = cur + AW'(c);
      rem = rem - c;
      exp_bursts++;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Request monitor: scoreboard, hold-stability, response scheduling.
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      int due;
      if (req_valid) valid_cycles++;
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (held && req_valid) begin
        check("hold_addr", req_addr, held_addr);
        check("hold_size", req_size_bytes, held_size);
      end
      if (req_valid && req_ready) begin
        check("burst_expected", exp_addr_q.size() > 0, 1'b1);
        if (exp_addr_q.size() > 0) begin
          check("burst_addr", req_addr, exp_addr_q.pop_front());
          check("burst_size", req_size_bytes, exp_size_q.pop_front());
          check("burst_dram", req_is_dram, exp_dram);
        end
        due = cyc + (rand_lat ? int'($urandom_range(1, 8)) : lat);
        if (pend_due_q.size() > 0 && due <= pend_due_q[$]) due = pend_due_q[$] + 1;
        pend_due_q.push_back(due);
        pend_size_q.push_back(int'(req_size_bytes));
      end
      held      = req_valid && !req_ready;
      held_addr = req_addr;
      held_size = req_size_bytes;
    end
  end

  // Responder and ready driver.
  always @(posedge clk) begin
    #1;
    resp_valid      = 1'b0;
    resp_size_bytes = '0;
    if (spur_req != spur_done) begin
      resp_valid      = 1'b1;
      resp_size_bytes = 16'd8;
      spur_done++;
    end else if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
      void'(pend_due_q.pop_front());
      resp_valid      = 1'b1;
      resp_size_bytes = SW'(pend_size_q.pop_front());
      if (corrupt_req != corrupt_done) begin
        resp_size_bytes = resp_size_bytes - 16'd1;
        corrupt_done++;
      end
      resp_sent++;
    end
    req_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_ctl;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic [AW-1:0] a, input logic [LW-1:0] len,
                           input logic dram, output int hs_cyc);
    plan(a, len, dram);
    desc_addr    = a;
    desc_len     = len;
    desc_is_dram = dram;
    desc_valid   = 1'b1;
    hs_cyc       = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (desc_ready) begin
        hs_cyc = cyc;
        step();
        desc_valid = 1'b0;
        return;
      end
    end
    check("desc_accept_timeout", desc_ready, 1'b1);
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic [2:0] st, output int dcyc);
    st   = 3'b111;
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        st   = done_status;
        dcyc = cyc;
        return;
      end
    end
    check("done_timeout", done, 1'b1);
  endtask

  initial begin
    int            hc, dc, n, cs0, vc0, rs0;
    logic [2:0]    st;
    logic [AW-1:0] ra;
    reset = 1'b1; desc_valid = 1'b0; desc_addr = '0; desc_len = '0;
    desc_is_dram = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_desc_ready", desc_ready, 1'b1);
    check("rst_outstanding", outstanding, 3'd0);
    check("rst_done", {done, done_status}, 4'd0);
    check("rst_bursts", bursts_issued, 32'd0);
    step();
    reset = 1'b0;

    // Directed split across boundaries, first request one cycle after handshake.
    send_desc(32'h1010, 32'd200, 1'b1, hc);
    @(negedge clk);
    check("first_req_latency", req_valid, 1'b1);
    wait_done(200, st, dc);
    check("t1_status", st, 3'b000);
    check("t1_desc_ready_at_done", desc_ready, 1'b0);
    check("t1_all_bursts", exp_addr_q.size(), 0);
    check("t1_bursts_issued", bursts_issued, exp_bursts);
    step();

    // Zero-length descriptor.
    vc0 = valid_cycles;
    send_desc(32'h2000, 32'd0, 1'b0, hc);
    wait_done(20, st, dc);
    check("len0_done_latency", dc - hc, 2);
    check("len0_status", st, 3'b000);
    check("len0_no_req", valid_cycles, vc0);
    step();
    @(negedge clk);
    check("len0_desc_ready_after", desc_ready, 1'b1);
    step();

    // Credit limit with long response latency.
    lat = 12; max_out = 0; cs0 = int'(credit_stall_cycles);
    send_desc(32'h0, 32'd512, 1'b0, hc);
    wait_done(400, st, dc);
    check("credit_status", st, 3'b000);
    check("credit_max_out", max_out, MO);
    check("credit_stall_seen", int'(credit_stall_cycles) != cs0, 1'b1);
    check("credit_bursts", bursts_issued, exp_bursts);
    step();

    // Backpressure on the first burst for five cycles.
    ready_ctl = 1'b0; lat = 2;
    step();
    ra = $urandom;
    send_desc(ra, 32'd100, 1'b1, hc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", req_valid, 1'b1);
    end
    ready_ctl = 1'b1;
    wait_done(200, st, dc);
    check("bp_status", st, 3'b000);
    check("bp_stall_cycles", bp_stall_cycles, 32'd5);
    step();

    // Abort coincident with the second handshake of a four-burst transfer.
    lat = 4; rs0 = resp_sent;
    send_desc(32'h4000, 32'd256, 1'b1, hc);
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin
        n++;
        if (n == 2) abort = 1'b1;
      end
    end
    wait_done(200, st, dc);
    check("abort_status", st, 3'b001);
    check("abort_bursts", bursts_issued, exp_bursts - 2);
    check("abort_responses", resp_sent - rs0, 2);
    step();
    abort = 1'b0;
    exp_bursts = exp_bursts - exp_addr_q.size();
    exp_addr_q.delete();
    exp_size_q.delete();

    // Spurious response while idle.
    spur_req++;
    repeat (3) step();
    @(negedge clk);
    check("spur_outstanding", outstanding, 3'd0);
    step();
    send_desc($urandom, LW'($urandom_range(1, 300)), 1'b0, hc);
    wait_done(400, st, dc);
    check("spur_status", st, 3'b100);
    step();
    send_desc(32'h3000, 32'd64, 1'b0, hc);
    wait_done(200, st, dc);
    check("spur_cleared", st, 3'b000);
    step();

    // Short response size gives a byte mismatch.
    corrupt_req++;
    send_desc(32'h5003, 32'd150, 1'b1, hc);
    wait_done(200, st, dc);
    check("mismatch_status", st, 3'b010);
    step();

    // Randomized transfers, including an address wrap.
    rand_ready = 1'b1; rand_lat = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) ra = 32'hFFFF_FFF0;
      else ra = $urandom;
      send_desc(ra, (k == 0) ? 32'd100 : LW'($urandom_range(0, 400)),
                1'($urandom_range(0, 1)), hc);
      wait_done(3000, st, dc);
      check("rand_status", st, 3'b000);
      check("rand_all_bursts", exp_addr_q.size(), 0);
      step();
    end
    rand_ready = 1'b0; rand_lat = 1'b0;
    check("rand_bursts_issued", bursts_issued, exp_bursts);

    // Reset in the middle of a transfer.
    ready_ctl = 1'b0;
    step();
    send_desc(32'h100, 32'd512, 1'b0, hc);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_req_valid", req_valid, 1'b0);
    check("mid_rst_desc_ready", desc_ready, 1'b1);
    check("mid_rst_counters", {bursts_issued, bp_stall_cycles}, 64'd0);
    check("mid_rst_credit", credit_stall_cycles, 32'd0);
    exp_addr_q.delete(); exp_size_q.delete();
    pend_due_q.delete(); pend_size_q.delete();
    exp_bursts = 0;
    ready_ctl = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_state", {desc_ready, req_valid, outstanding}, 5'b10000);
    step();
    send_desc(32'h40, 32'd64, 1'b0, hc);
    wait_done(100, st, dc);
    check("post_rst_status", st, 3'b000);
    check("post_rst_bursts", bursts_issued, exp_bursts);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
